fifo_word_unpacker: RTL
=======================

// Module: fifo_word_unpacker
// PURPOSE
//  Read-side controller for the 8-deep x 32-bit synchronous FIFO buffer. On a start
//  command it drains a programmed number of words from the FIFO using its RD/EMPTY
//  interface, splits each word into ELEM_W-bit elements, and streams them out over
//  a valid/ready handshake to the CNN processing-element input.
//  The FIFO EN input is tied high at the top level; this block drives only FIFO RD.
// PARAMETERS
//  WORD_W   32  FIFO word width; must equal FIFO data width.
//  ELEM_W   8   output element width; WORD_W % ELEM_W == 0.
//  LEN_W    8   width of word-count field; max burst 2**LEN_W-1 words.
//  Derived: ELEMS = WORD_W/ELEM_W (4 by default); IDX_W = clog2(ELEMS).
// PORTS
//  Clk        in   1       clock; all state updates on rising edge.
//  Rst        in   1       reset, synchronous, active-high.
//  start      in   1       one-cycle command; sampled only in IDLE.
//  len        in   LEN_W   words to drain; sampled with start.
//  fifo_empty in   1       FIFO EMPTY flag.
//  fifo_data  in   WORD_W  FIFO dataOut; valid in the cycle after a RD cycle.
//  fifo_rd    out  1       FIFO RD strobe; combinational from state and fifo_empty.
//  out_data   out  ELEM_W  current element.
//  out_valid  out  1       out_data valid.
//  out_ready  in   1       consumer accepts the element when out_valid & out_ready.
//  out_last   out  1       marks the final element of the final word.
//  busy       out  1       high in REQ, WAIT and EMIT.
//  done       out  1       one-cycle pulse when the burst completes.
// BEHAVIOUR
//  Reset: state = IDLE. out_valid, out_last, busy, done and fifo_rd = 0.
//    Internal counters and out_data = 0.
//  Rst takes priority over every other input. Rst in any state returns to IDLE on
//    the next edge. A burst aborted by reset does not pulse done.
//  IDLE:
//    start & len != 0: capture len into words_left, go to REQ.
//    start & len == 0: done = 1 in the next cycle, stay in IDLE, no FIFO read.
//  REQ:
//    fifo_rd = ~fifo_empty. When fifo_rd = 1, go to WAIT.
//    Otherwise stall in REQ with busy = 1 and out_valid = 0.
//  WAIT:
//    fifo_rd = 0. At the closing edge: shreg <= fifo_data; words_left--; idx = 0;
//    go to EMIT.
//  EMIT:
//    out_valid = 1; out_data = shreg[ELEM_W-1:0]. Elements are sent LS element first.
//    On accept: shreg >>= ELEM_W and idx++.
//    On accept with idx == ELEMS-1: go to REQ if words_left != 0, otherwise go to DONE.
//    While out_valid & ~out_ready, out_data and out_last stay stable.
//  DONE: done = 1 and busy = 0 for one cycle, then go to IDLE.
//  out_last = 1 only in EMIT with idx == ELEMS-1 and words_left == 0.
//  start is ignored outside IDLE; a burst already running is not disturbed.
//  fifo_rd is never asserted while fifo_empty = 1 or outside REQ.
//    Exactly len RD strobes are issued per burst.
//  Throughput: (ELEMS + 2) cycles per word with out_ready = 1 and FIFO non-empty.
//  words_left never underflows; len = 2**LEN_W-1 is supported.
// TESTING
//  T1 Nominal burst:
//    Stimulus: FIFO holds 0x44332211, 0x88776655; start with len=2; out_ready=1.
//    Response: out_data = 11,22,33,44,55,66,77,88; out_last only with 88;
//      two fifo_rd pulses (cycles 1 and 7); done in cycle 13 after start is sampled.
//  T2 Empty stall:
//    Stimulus: FIFO empty at start (len=1); write 0xDEADBEEF 5 cycles later.
//    Response: fifo_rd = 0 and busy = 1 while empty; after the write,
//      elements EF,BE,AD,DE follow; then done.
//  T3 Backpressure:
//    Stimulus: len=1, word 0x04030201; out_ready pattern 0,1,0,1,1,0,1.
//    Response: output 01,02,03,04 each accepted exactly once;
//      out_data stable while stalled.
//  T4 Zero length:
//    Stimulus: start with len=0.
//    Response: done pulses the next cycle; fifo_rd, busy and out_valid stay 0.
//  T5 Reset mid-burst:
//    Stimulus: Rst asserted in EMIT at idx=2.
//    Response: next cycle IDLE with all outputs 0 and no done pulse;
//      a following start with len=1 completes normally.
//  T6 Start while busy:
//    Stimulus: second start with len=5 during a len=2 burst.
//    Response: it is ignored; exactly 2 words are read and 8 elements are output.

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// Read-side FIFO controller: drains a programmed burst of words and
// streams each word out as ELEM_W-bit elements, LS element first.
module fifo_word_unpacker #(
   parameter int WORD_W = 32,
   parameter int ELEM_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              fifo_empty,
   input  logic [WORD_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic [ELEM_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int ELEMS = WORD_W / ELEM_W;
   localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [LEN_W-1:0]   r_words_left;
   logic [WORD_W-1:0]  r_shreg;
   logic [IDX_W-1:0]   r_idx;
   logic               r_zdone;
   logic               w_last_elem;
   logic               w_zero_cmd;

   assign w_last_elem = (r_idx == IDX_W'(ELEMS - 1));
   assign w_zero_cmd  = (r_state == S_IDLE) & start & (len == '0);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= S_IDLE;
         r_words_left <= '0;
         r_shreg      <= '0;
         r_idx        <= '0;
         r_zdone      <= 1'b0;
      end else begin
         r_state <= w_next;
         // Zero-length command finishes without leaving IDLE
         r_zdone <= w_zero_cmd;
         unique case (r_state)
            S_IDLE: begin
               if (start && len != '0)
                  r_words_left <= len;
            end
            S_WAIT: begin
               r_shreg      <= fifo_data;
               r_words_left <= r_words_left - LEN_W'(1);
               r_idx        <= '0;
            end
            S_EMIT: begin
               if (out_ready) begin
                  r_shreg <= r_shreg >> ELEM_W;
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      fifo_rd   = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = r_zdone;
      unique case (r_state)
         S_IDLE: begin
            if (start && len != '0)
               w_next = S_REQ;
         end
         S_REQ: begin
            busy    = 1'b1;
            fifo_rd = ~fifo_empty;
            if (!fifo_empty)
               w_next = S_WAIT;
         end
         S_WAIT: begin
            busy   = 1'b1;
            w_next = S_EMIT;
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && w_last_elem)
               w_next = (r_words_left != '0) ? S_REQ : S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign out_data = r_shreg[ELEM_W-1:0];
   assign out_last = (r_state == S_EMIT) & w_last_elem &
                     (r_words_left == '0);

endmodule
